// File: rtl/fifo_sync_param.sv
// Single-clock parameterised FIFO with registered read data, level flags
// and sticky overflow/underflow error flags.
module fifo_sync_param #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned AF_THRESH = 56,
   parameter int unsigned AE_THRESH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] buf_in,
   input  logic              wr_en,
   input  logic              rd_en,
   output logic [DATA_W-1:0] buf_out,
   output logic              buf_empty,
   output logic              buf_full,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   fifo_counter,
   output logic              overflow,
   output logic              underflow
);

   localparam int unsigned    Depth   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] CntFull = (ADDR_W + 1)'(Depth);
   localparam logic [ADDR_W:0] CntAf   = (ADDR_W + 1)'(AF_THRESH);
   localparam logic [ADDR_W:0] CntAe   = (ADDR_W + 1)'(AE_THRESH);

   logic [DATA_W-1:0] r_mem [Depth];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic [DATA_W-1:0] r_buf_out;
   logic              r_overflow;
   logic              r_underflow;

   logic              w_wr_acc;
   logic              w_rd_acc;

   // Flags decode the count directly so they track it in the same cycle.
   assign buf_empty    = (r_count == '0);
   assign buf_full     = (r_count == CntFull);
   assign almost_full  = (r_count >= CntAf);
   assign almost_empty = (r_count <= CntAe);

   assign w_wr_acc = wr_en & ~buf_full;
   assign w_rd_acc = rd_en & ~buf_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_buf_out   <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
            r_buf_out <= r_mem[r_rd_ptr];
         end
         if (w_wr_acc && !w_rd_acc) begin
            r_count <= r_count + (ADDR_W + 1)'(1);
         end else if (w_rd_acc && !w_wr_acc) begin
            r_count <= r_count - (ADDR_W + 1)'(1);
         end
         if (wr_en && buf_full) begin
            r_overflow <= 1'b1;
         end
         if (rd_en && buf_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   // Storage is never cleared; reset only discards contents via the pointers.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_acc) begin
         r_mem[r_wr_ptr] <= buf_in;
      end
   end

   assign buf_out      = r_buf_out;
   assign fifo_counter = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench: a default-size and a small 16-bit FIFO run the same stimulus
// against queue-based reference models; read data is checked by separate monitors.
module tb_fifo_sync_param;

   typedef logic [15:0] word_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   logic  wr_en = 1'b0;
   logic  rd_en = 1'b0;
   word_t din = '0;

   always #5 clk = ~clk;

   logic [7:0]  a_out;
   logic        a_empty, a_full, a_af, a_ae, a_ovf, a_unf;
   logic [6:0]  a_cnt;
   logic [15:0] b_out;
   logic        b_empty, b_full, b_af, b_ae, b_ovf, b_unf;
   logic [3:0]  b_cnt;

   fifo_sync_param u_dut_a (
      .clk         (clk),
      .rst         (rst),
      .buf_in      (din[7:0]),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .buf_out     (a_out),
      .buf_empty   (a_empty),
      .buf_full    (a_full),
      .almost_full (a_af),
      .almost_empty(a_ae),
      .fifo_counter(a_cnt),
      .overflow    (a_ovf),
      .underflow   (a_unf)
   );

   fifo_sync_param #(
      .DATA_W   (16),
      .ADDR_W   (3),
      .AF_THRESH(6),
      .AE_THRESH(1)
   ) u_dut_b (
      .clk         (clk),
      .rst         (rst),
      .buf_in      (din),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .buf_out     (b_out),
      .buf_empty   (b_empty),
      .buf_full    (b_full),
      .almost_full (b_af),
      .almost_empty(b_ae),
      .fifo_counter(b_cnt),
      .overflow    (b_ovf),
      .underflow   (b_unf)
   );

   int checks = 0;
   int errors = 0;

   // Reference models: contents, pending expected read data, last read value, sticky flags.
   word_t qa[$];
   word_t qb[$];
   word_t ea[$];
   word_t eb[$];
   word_t oa = '0;
   word_t ob = '0;
   logic  ma_ovf = 1'b0, ma_unf = 1'b0;
   logic  mb_ovf = 1'b0, mb_unf = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(ref word_t q[$], ref word_t e[$], ref word_t mout,
                             ref logic ovf, ref logic unf,
                             input int depth, input word_t mask);
      int n;
      n = q.size();
      if (rst) begin
         q.delete();
         mout = '0;
         ovf  = 1'b0;
         unf  = 1'b0;
      end else begin
         if (wr_en && n == depth) ovf = 1'b1;
         if (rd_en && n == 0) unf = 1'b1;
         if (rd_en && n != 0) begin
            mout = q.pop_front();
            e.push_back(mout);
         end
         if (wr_en && n != depth) q.push_back(din & mask);
      end
   endtask

   task automatic state_chk(input string tag, input logic [31:0] cnt, input logic emp,
                            input logic full, input logic af, input logic ae,
                            input logic ovf, input logic unf, input logic [31:0] out,
                            input int mcnt, input int depth, input int afth, input int aeth,
                            input logic movf, input logic munf, input word_t mout);
      chk({tag, " count"}, cnt, 32'(mcnt));
      chk({tag, " empty"}, 32'(emp), 32'(mcnt == 0));
      chk({tag, " full"}, 32'(full), 32'(mcnt == depth));
      chk({tag, " almost_full"}, 32'(af), 32'(mcnt >= afth));
      chk({tag, " almost_empty"}, 32'(ae), 32'(mcnt <= aeth));
      chk({tag, " overflow"}, 32'(ovf), 32'(movf));
      chk({tag, " underflow"}, 32'(unf), 32'(munf));
      chk({tag, " buf_out"}, out, 32'(mout));
   endtask

   // One clock: drive on the falling edge, update models at the rising edge,
   // then compare architectural state just after it.
   task automatic cyc(input logic r, input logic w, input logic rd, input word_t d);
      @(negedge clk);
      rst   = r;
      wr_en = w;
      rd_en = rd;
      din   = d;
      @(posedge clk);
      model_step(qa, ea, oa, ma_ovf, ma_unf, 64, 16'h00ff);
      model_step(qb, eb, ob, mb_ovf, mb_unf, 8, 16'hffff);
      #1;
      state_chk("A", 32'(a_cnt), a_empty, a_full, a_af, a_ae, a_ovf, a_unf, 32'(a_out),
                qa.size(), 64, 56, 8, ma_ovf, ma_unf, oa);
      state_chk("B", 32'(b_cnt), b_empty, b_full, b_af, b_ae, b_ovf, b_unf, 32'(b_out),
                qb.size(), 8, 6, 1, mb_ovf, mb_unf, ob);
   endtask

   task automatic wr_n(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
   endtask

   task automatic rd_n(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 16'($urandom));
   endtask

   task automatic both_n(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, 16'($urandom));
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 1'b0, '0);
   endtask

   // Read-data monitors: an accepted read at an edge must present the oldest expected word.
   logic mon_acc_a;
   logic mon_acc_b;

   always @(posedge clk) begin
      mon_acc_a = !rst && rd_en && !a_empty;
      #1;
      if (mon_acc_a) begin
         if (ea.size() == 0) chk("A scoreboard underrun", 32'(ea.size()), 32'd1);
         else chk("A read data", 32'(a_out), 32'(ea.pop_front()));
      end
   end

   always @(posedge clk) begin
      mon_acc_b = !rst && rd_en && !b_empty;
      #1;
      if (mon_acc_b) begin
         if (eb.size() == 0) chk("B scoreboard underrun", 32'(eb.size()), 32'd1);
         else chk("B read data", 32'(b_out), 32'(eb.pop_front()));
      end
   end

   int pw [6] = '{70, 30, 50, 90, 60, 40};
   int pr [6] = '{30, 70, 50, 90, 40, 60};

   initial begin
      do_reset();
      do_reset();

      // Small ordered transfer.
      cyc(1'b0, 1'b1, 1'b0, 16'd11);
      cyc(1'b0, 1'b1, 1'b0, 16'd12);
      cyc(1'b0, 1'b1, 1'b0, 16'd13);
      rd_n(3);

      // Fill past full, then drain past empty.
      wr_n(65);
      rd_n(65);

      // Underflow on empty must persist until reset.
      do_reset();
      rd_n(1);
      cyc(1'b0, 1'b0, 1'b0, '0);
      wr_n(2);
      rd_n(2);
      do_reset();

      // Simultaneous read/write at mid level, full and empty.
      wr_n(5);
      both_n(10);
      wr_n(59);
      both_n(1);
      rd_n(63);
      both_n(1);
      rd_n(1);
      do_reset();

      // Pointer wrap, then reset in mid-operation.
      wr_n(40);
      rd_n(40);
      wr_n(64);
      rd_n(64);
      wr_n(30);
      do_reset();
      cyc(1'b0, 1'b0, 1'b0, '0);

      // Randomised traffic with changing read/write bias and occasional reset.
      for (int blk = 0; blk < 6; blk++) begin
         for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 99) < pw[blk]),
                ($urandom_range(0, 99) < pr[blk]),
                16'($urandom));
         end
      end

      cyc(1'b0, 1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, 1'b0, '0);
      chk("A leftover expected reads", 32'(ea.size()), 32'd0);
      chk("B leftover expected reads", 32'(eb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 6, pointer width; DEPTH = 2**ADDR_W (64 by default).
REQ-003 SHALL provide parameter AF_THRESH, default 56, almost_full assertion level in words.
REQ-004 SHALL provide parameter AE_THRESH, default 8, almost_empty assertion level in words.
REQ-005 SHALL port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL port buf_in  input  DATA_W  write data.
REQ-008 SHALL port wr_en  input  1  write request.
REQ-009 SHALL port rd_en  input  1  read request.
REQ-010 SHALL port buf_out  output  DATA_W  registered read data.
REQ-011 SHALL port buf_empty  output  1  count == 0.
REQ-012 SHALL port buf_full  output  1  count == DEPTH.
REQ-013 SHALL port almost_full  output  1  count >= AF_THRESH.
REQ-014 SHALL port almost_empty  output  1  count <= AE_THRESH.
REQ-015 SHALL port fifo_counter  output  ADDR_W+1  words currently stored (0..DEPTH).
REQ-016 SHALL port overflow  output  1  sticky: write attempted while full.
REQ-017 SHALL port underflow  output  1  sticky: read attempted while empty.

Function
REQ-018 Storage SHALL be DEPTH x DATA_W array with ADDR_W-bit wr_ptr and rd_ptr, wrapping DEPTH-1 -> 0 with no extra logic.
REQ-019 Write SHALL be accepted iff wr_en=1 and buf_full=0 at the edge; accepted write stores buf_in at wr_ptr, wr_ptr+1.
REQ-020 Read SHALL be accepted iff rd_en=1 and buf_empty=0 at the edge; accepted read loads buf_out with mem[rd_ptr], rd_ptr+1; data visible one cycle after the accepting edge.
REQ-021 buf_out SHALL hold its last value when no read is accepted.
REQ-022 fifo_counter SHALL +1 on write-only accept, -1 on read-only accept, unchanged when both or neither accepted.
REQ-023 Simultaneous wr_en/rd_en with 0<count<DEPTH SHALL accept both; count unchanged.
REQ-024 Simultaneous wr_en/rd_en when full SHALL accept read only, reject write, set overflow.
REQ-025 Simultaneous wr_en/rd_en when empty SHALL accept write only, reject read, set underflow; no fall-through of new data.
REQ-026 Rejected write/read SHALL leave memory, pointers, count and buf_out unchanged.
REQ-027 Flags buf_empty, buf_full, almost_full, almost_empty SHALL be combinational decodes of fifo_counter, valid same cycle as count.
REQ-028 overflow/underflow SHALL stay set once set, cleared only by rst.
REQ-029 Legal parameters SHALL satisfy ADDR_W>=1 and 0 <= AE_THRESH < AF_THRESH <= DEPTH; other values unsupported.

Reset
REQ-030 rst=1 at an edge SHALL zero wr_ptr, rd_ptr, fifo_counter, buf_out, overflow, underflow; wr_en/rd_en ignored that cycle.
REQ-031 After reset SHALL present buf_empty=1, almost_empty=1, buf_full=0, almost_full=0 (defaults).
REQ-032 Reset mid-operation SHALL discard stored contents logically; memory array need not be cleared.

Verification
REQ-033 Reset then write 11,12,13, read x3 -> buf_out 11,12,13 each one cycle after its read edge; count 3->0; buf_empty=1.
REQ-034 Write 64 random words -> buf_full=1, count=64, almost_full from count 56; 65th write -> overflow=1, count stays 64; read 64 -> data in order, buf_empty=1, almost_empty from count 8.
REQ-035 Empty FIFO, rd_en pulse -> underflow=1, buf_out unchanged, count 0; underflow persists until rst.
REQ-036 Count 5, wr_en=rd_en=1 for 10 cycles -> count stays 5, data order preserved; at full, both asserted -> count 63, overflow=1; at empty, both -> count 1, underflow=1.
REQ-037 Write 40, read 40, write 64 (pointer wrap) -> full at 64, readback order exact; rst asserted at count 30 -> next cycle count 0, flags at reset values, buf_out 0.
REQ-038 Rebuild with DATA_W=16, ADDR_W=3, AF_THRESH=6, AE_THRESH=1 -> full at 8, almost_full at 6, almost_empty at <=1, 16-bit data intact.
